// File: rtl/main_memory_ctrl_pkg.sv
// Shared types for the main memory controller: bus address layout,
// block type, controller states and default access latencies.
package main_memory_ctrl_pkg;

   localparam int BLOCKBYTES = 4;
   localparam int TAGBITS    = 24;
   localparam int INDEXBITS  = 6;
   localparam int OFFBITS    = 2;
   localparam int BLKNUM_W   = TAGBITS + INDEXBITS;
   localparam int CNT_W      = 8;

   localparam int DEF_RD_LATENCY = 4;
   localparam int DEF_WR_LATENCY = 4;

   typedef struct packed {
      logic [TAGBITS-1:0]   TAG;
      logic [INDEXBITS-1:0] INDEX;
      logic [OFFBITS-1:0]   BYTESELECT;
   } ADDRESS;

   typedef logic [BLOCKBYTES-1:0][7:0] MEMBLOCK;

   typedef enum logic [1:0] {
      IDLE,
      WR_WAIT,
      RD_WAIT,
      RESP
   } mem_state_e;

   function automatic logic [BLKNUM_W-1:0] blk_num(input ADDRESS a);
      return {a.TAG, a.INDEX};
   endfunction

endpackage

// File: rtl/main_memory_ctrl_mem_array.sv
// Single-port synchronous block RAM with write enable and a registered,
// read-enabled output that holds between reads.
module main_memory_ctrl_mem_array #(
   parameter int DEPTH      = 1024,
   parameter int BLOCKBYTES = 4,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       we_i,
   input  logic                       re_i,
   input  logic [AW-1:0]              addr_i,
   input  logic [BLOCKBYTES-1:0][7:0] wdata_i,
   output logic [BLOCKBYTES-1:0][7:0] rdata_o
);

   logic [BLOCKBYTES-1:0][7:0] mem_q [DEPTH];
   logic [BLOCKBYTES-1:0][7:0] rdata_q;

   // Storage is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Block-granular main memory: fills and write-backs with programmable
// latency, READY pulse on completion, BUSY while a request is in flight.
module main_memory_ctrl
   import main_memory_ctrl_pkg::*;
#(
   parameter int MEM_BLOCKS = 1024,
   parameter int RD_LATENCY = DEF_RD_LATENCY,
   parameter int WR_LATENCY = DEF_WR_LATENCY,
   parameter int BLOCKBYTES = main_memory_ctrl_pkg::BLOCKBYTES
) (
   input  logic                       clock,
   input  logic                       reset,
   input  ADDRESS                     address,
   input  logic                       READ,
   input  logic                       WRITE,
   input  logic [BLOCKBYTES-1:0][7:0] DataOut,
   output logic [BLOCKBYTES-1:0][7:0] DataIn,
   output logic                       READY,
   output logic                       BUSY
);

   localparam int IW = $clog2(MEM_BLOCKS);

   mem_state_e                 state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [BLOCKBYTES-1:0][7:0] wdat_q, wdat_d;
   logic                       pend_q, pend_d;
   logic                       we, re;
   logic [BLKNUM_W-1:0]        blk;
   logic [IW-1:0]              idx_in;
   logic                       unused_bits;

   // Upper block-number bits wrap silently.
   assign blk         = blk_num(address);
   assign idx_in      = blk[IW-1:0];
   assign unused_bits = ^{blk[BLKNUM_W-1:IW], address.BYTESELECT};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdat_d  = wdat_q;
      pend_d  = pend_q;
      we      = 1'b0;
      re      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (WRITE) begin
               idx_d   = idx_in;
               wdat_d  = DataOut;
               pend_d  = READ;
               cnt_d   = CNT_W'(WR_LATENCY - 1);
               state_d = WR_WAIT;
            end else if (READ) begin
               idx_d   = idx_in;
               cnt_d   = CNT_W'(RD_LATENCY - 1);
               state_d = RD_WAIT;
            end
         end
         WR_WAIT: begin
            if (cnt_q == '0) begin
               we = 1'b1;
               // Commit before the fill so a combined request reads new data.
               if (pend_q) begin
                  pend_d  = 1'b0;
                  cnt_d   = CNT_W'(RD_LATENCY - 1);
                  state_d = RD_WAIT;
               end else begin
                  state_d = RESP;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               re      = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdat_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdat_q  <= wdat_d;
         pend_q  <= pend_d;
      end
   end

   assign READY = (state_q == RESP);
   assign BUSY  = (state_q == WR_WAIT) || (state_q == RD_WAIT);

   main_memory_ctrl_mem_array #(
      .DEPTH      (MEM_BLOCKS),
      .BLOCKBYTES (BLOCKBYTES)
   ) u_array (
      .clk_i   (clock),
      .rst_i   (reset),
      .we_i    (we),
      .re_i    (re),
      .addr_i  (idx_q),
      .wdata_i (wdat_q),
      .rdata_o (DataIn)
   );

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Bench for main_memory_ctrl: directed scenarios plus random traffic
// checked against an associative-array memory model.
module tb_main_memory_ctrl;
   import main_memory_ctrl_pkg::*;

   localparam int MB = 1024;
   localparam int RL = 4;
   localparam int WL = 4;

   logic    clock = 1'b0;
   logic    reset;
   ADDRESS  address;
   logic    READ, WRITE;
   MEMBLOCK DataOut, DataIn;
   logic    READY, BUSY;

   int n_cmp = 0;
   int n_bad = 0;
   MEMBLOCK ref_mem [int];

   main_memory_ctrl #(
      .MEM_BLOCKS (MB),
      .RD_LATENCY (RL),
      .WR_LATENCY (WL)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .address (address),
      .READ    (READ),
      .WRITE   (WRITE),
      .DataOut (DataOut),
      .DataIn  (DataIn),
      .READY   (READY),
      .BUSY    (BUSY)
   );

   always #5 clock = ~clock;

   function automatic ADDRESS mk_addr(input int unsigned blk);
      logic [31:0] t;
      t = {blk[29:0], 2'($urandom)};
      return ADDRESS'(t);
   endfunction

   // Reference: memory as a map from block number mod MB; latency from rules.
   task automatic model(input bit wr, input bit rd, input int unsigned blk,
                        input MEMBLOCK d, output int exp_lat,
                        output MEMBLOCK exp_d);
      int idx;
      idx = int'(blk % MB);
      if (wr) ref_mem[idx] = d;
      if (wr && rd) exp_lat = WL + RL + 1;
      else if (wr)  exp_lat = WL + 1;
      else          exp_lat = RL + 1;
      exp_d = ref_mem.exists(idx) ? ref_mem[idx] : '0;
   endtask

   task automatic run_txn(input bit wr, input bit rd, input int unsigned blk,
                          input MEMBLOCK d, output int lat, output int pulses);
      @(negedge clock);
      address = mk_addr(blk);
      WRITE   = wr;
      READ    = rd;
      DataOut = d;
      @(posedge clock);
      #1;
      WRITE   = 1'b0;
      READ    = 1'b0;
      address = mk_addr($urandom);
      DataOut = $urandom;
      lat     = 0;
      pulses  = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clock);
         if (READY) begin
            pulses++;
            if (lat == 0) lat = n;
         end
         if (lat != 0 && n >= lat + 2) break;
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      READ    = 1'b0;
      WRITE   = 1'b0;
      address = '0;
      DataOut = '0;
      #1;
      n_cmp++;
      if (READY !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ready got %b want 0", READY);
      end
      n_cmp++;
      if (BUSY !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_busy got %b want 0", BUSY);
      end
      n_cmp++;
      if (DataIn !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_datain got %h want 0", DataIn);
      end
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_write_read();
      int lat, pulses, el;
      MEMBLOCK ed;
      model(1'b1, 1'b0, 5, 32'h11223344, el, ed);
      run_txn(1'b1, 1'b0, 5, 32'h11223344, lat, pulses);
      n_cmp++;
      if (lat !== el || pulses !== 1) begin
         n_bad++;
         $display("FAIL wr_lat got %0d/%0d want %0d/1", lat, pulses, el);
      end
      model(1'b0, 1'b1, 5, '0, el, ed);
      run_txn(1'b0, 1'b1, 5, '0, lat, pulses);
      n_cmp++;
      if (lat !== el || pulses !== 1) begin
         n_bad++;
         $display("FAIL rd_lat got %0d/%0d want %0d/1", lat, pulses, el);
      end
      n_cmp++;
      if (DataIn !== ed) begin
         n_bad++;
         $display("FAIL rd_data got %h want %h", DataIn, ed);
      end
   endtask

   task automatic test_combined();
      int lat, pulses, el;
      MEMBLOCK ed;
      model(1'b1, 1'b1, 9, 32'hA5A5A5A5, el, ed);
      run_txn(1'b1, 1'b1, 9, 32'hA5A5A5A5, lat, pulses);
      n_cmp++;
      if (lat !== 9 || lat !== el || pulses !== 1) begin
         n_bad++;
         $display("FAIL comb_lat got %0d/%0d want %0d/1", lat, pulses, el);
      end
      n_cmp++;
      if (DataIn !== 32'hA5A5A5A5) begin
         n_bad++;
         $display("FAIL comb_data got %h want a5a5a5a5", DataIn);
      end
   endtask

   task automatic test_busy_drop();
      int lat, pulses, el;
      MEMBLOCK ed;
      bit busy_seen;
      model(1'b1, 1'b0, 2, 32'h0BAD0001, el, ed);
      run_txn(1'b1, 1'b0, 2, 32'h0BAD0001, lat, pulses);
      @(negedge clock);
      address = mk_addr(2);
      READ    = 1'b1;
      @(posedge clock);
      #1 READ = 1'b0;
      lat       = 0;
      pulses    = 0;
      busy_seen = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (n == 2) begin
            busy_seen = BUSY;
            address   = mk_addr(2);
            WRITE     = 1'b1;
            DataOut   = 32'hDEADBEEF;
         end
         if (n == 3) WRITE = 1'b0;
         if (READY) begin
            pulses++;
            if (lat == 0) lat = n;
         end
      end
      n_cmp++;
      if (busy_seen !== 1'b1) begin
         n_bad++;
         $display("FAIL drop_busy got %b want 1", busy_seen);
      end
      n_cmp++;
      if (lat !== RL + 1 || pulses !== 1) begin
         n_bad++;
         $display("FAIL drop_pulses got %0d/%0d want %0d/1", lat, pulses, RL + 1);
      end
      model(1'b0, 1'b1, 2, '0, el, ed);
      run_txn(1'b0, 1'b1, 2, '0, lat, pulses);
      n_cmp++;
      if (DataIn !== 32'h0BAD0001) begin
         n_bad++;
         $display("FAIL drop_data got %h want 0bad0001", DataIn);
      end
   endtask

   task automatic test_wrap();
      int lat, pulses, el;
      MEMBLOCK ed;
      model(1'b1, 1'b0, MB + 3, 32'h3C3C0303, el, ed);
      run_txn(1'b1, 1'b0, MB + 3, 32'h3C3C0303, lat, pulses);
      model(1'b0, 1'b1, 3, '0, el, ed);
      run_txn(1'b0, 1'b1, 3, '0, lat, pulses);
      n_cmp++;
      if (DataIn !== 32'h3C3C0303 || lat !== el) begin
         n_bad++;
         $display("FAIL wrap got %h lat %0d want 3c3c0303 lat %0d", DataIn, lat, el);
      end
   endtask

   task automatic test_held();
      int first, second;
      bit idle_busy;
      first  = 0;
      second = 0;
      @(negedge clock);
      address = mk_addr(5);
      READ    = 1'b1;
      @(posedge clock);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (READY) begin
            first = n;
            break;
         end
      end
      @(posedge clock);
      @(negedge clock);
      idle_busy = BUSY | READY;
      @(posedge clock);
      #1 READ = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (READY) begin
            second = n;
            break;
         end
      end
      n_cmp++;
      if (first !== RL + 1 || second !== RL + 1) begin
         n_bad++;
         $display("FAIL held_lat got %0d,%0d want %0d,%0d", first, second, RL + 1, RL + 1);
      end
      n_cmp++;
      if (idle_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL held_idle got %b want 0", idle_busy);
      end
      n_cmp++;
      if (DataIn !== 32'h11223344) begin
         n_bad++;
         $display("FAIL held_data got %h want 11223344", DataIn);
      end
      @(negedge clock);
   endtask

   task automatic test_reset_mid_write();
      int lat, pulses, el, cnt;
      MEMBLOCK ed;
      model(1'b1, 1'b1, 7, 32'h77665544, el, ed);
      run_txn(1'b1, 1'b1, 7, 32'h77665544, lat, pulses);
      @(negedge clock);
      address = mk_addr(7);
      WRITE   = 1'b1;
      DataOut = 32'hFFFF0000;
      @(posedge clock);
      #1 WRITE = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (BUSY !== 1'b0 || READY !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_out got busy %b ready %b want 0 0", BUSY, READY);
      end
      n_cmp++;
      if (DataIn !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_mid_data got %h want 0", DataIn);
      end
      @(negedge clock);
      reset = 1'b0;
      cnt   = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         if (READY) cnt++;
      end
      n_cmp++;
      if (cnt !== 0) begin
         n_bad++;
         $display("FAIL rst_mid_ready got %0d pulses want 0", cnt);
      end
      model(1'b0, 1'b1, 7, '0, el, ed);
      run_txn(1'b0, 1'b1, 7, '0, lat, pulses);
      n_cmp++;
      if (DataIn !== ed || ed !== 32'h77665544) begin
         n_bad++;
         $display("FAIL rst_mid_keep got %h want %h", DataIn, ed);
      end
   endtask

   task automatic test_random();
      int lat, pulses, el;
      int unsigned blk;
      bit wr, rd;
      MEMBLOCK d, ed;
      for (int i = 0; i < 30; i++) begin
         blk = $urandom_range(0, 15) + MB * $urandom_range(0, 3);
         wr  = 1'($urandom);
         rd  = 1'($urandom);
         if (!wr && !rd) rd = 1'b1;
         if (rd && !ref_mem.exists(int'(blk % MB))) wr = 1'b1;
         d = $urandom;
         model(wr, rd, blk, d, el, ed);
         run_txn(wr, rd, blk, d, lat, pulses);
         n_cmp++;
         if (lat !== el || pulses !== 1) begin
            n_bad++;
            $display("FAIL rand_lat[%0d] got %0d/%0d want %0d/1", i, lat, pulses, el);
         end
         if (rd) begin
            n_cmp++;
            if (DataIn !== ed) begin
               n_bad++;
               $display("FAIL rand_data[%0d] got %h want %h", i, DataIn, ed);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_combined();
      test_busy_drop();
      test_wrap();
      test_held();
      test_reset_mid_write();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
